// File: rtl/alphasoc_bus_arbiter.sv
// Two-master round-robin arbiter for the native SoC memory bus, with a transaction watchdog.
// Latency: one cycle from request to s_valid; master ready is combinational from s_ready.
// Backpressure: the granted master waits on s_ready; the other master is held off until the bus returns to IDLE.
//
// Ports:
//   clk, reset                     clock and asynchronous active-high reset
//   m0_* / m1_*                    CPU and DMA/debug master request/response
//   s_*                            shared downstream request/response
//   err_timeout, err_master        sticky timeout flag and the master that caused it
//   err_clear                      clears err_timeout (a new timeout in the same cycle wins)
module alphasoc_bus_arbiter #(
    parameter int          TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic        err_timeout,
    output logic        err_master,
    input  logic        err_clear
);

    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t        state, state_nxt;
    logic          prio, prio_nxt;
    logic [WW-1:0] wdog, wdog_nxt;
    logic          cur;        // granted master index while in a GNT state
    logic          a_valid;
    logic          done;
    logic [31:0]   done_rdata;
    logic          err_set;

    assign cur = (state == GNT1);

    always_comb begin
        state_nxt  = state;
        prio_nxt   = prio;
        wdog_nxt   = wdog;
        s_valid    = 1'b0;
        s_addr     = 32'h0;
        s_wdata    = 32'h0;
        s_wstrb    = 4'h0;
        a_valid    = 1'b0;
        done       = 1'b0;
        done_rdata = 32'h0;
        err_set    = 1'b0;

        case (state)
            IDLE: begin
                if (m0_valid && (!m1_valid || !prio))
                    state_nxt = GNT0;
                else if (m1_valid)
                    state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                a_valid = cur ? m1_valid : m0_valid;
                s_valid = a_valid;
                s_addr  = cur ? m1_addr  : m0_addr;
                s_wdata = cur ? m1_wdata : m0_wdata;
                s_wstrb = cur ? m1_wstrb : m0_wstrb;
                if (!a_valid) begin
                    // Master abandoned the request: release the bus silently.
                    state_nxt = IDLE;
                end else if (s_ready) begin
                    // A real completion on the timeout cycle takes precedence.
                    done       = 1'b1;
                    done_rdata = s_rdata;
                    state_nxt  = IDLE;
                    prio_nxt   = ~cur;
                end else if (wdog == WDOG_MAX) begin
                    done       = 1'b1;
                    done_rdata = ERR_DATA;
                    err_set    = 1'b1;
                    state_nxt  = IDLE;
                    prio_nxt   = ~cur;
                end else begin
                    wdog_nxt = wdog + WW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == IDLE)
            wdog_nxt = '0;
    end

    assign m0_ready = done & ~cur;
    assign m1_ready = done &  cur;
    assign m0_rdata = m0_ready ? done_rdata : 32'h0;
    assign m1_rdata = m1_ready ? done_rdata : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            prio  <= 1'b0;
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            wdog  <= wdog_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_timeout <= 1'b0;
            err_master  <= 1'b0;
        end else if (err_set) begin
            err_timeout <= 1'b1;
            err_master  <= cur;
        end else if (err_clear) begin
            err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alphasoc_bus_arbiter.sv
module tb_alphasoc_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        err_timeout, err_master, err_clear;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int slave_lat = -1;          // -1: slave never acknowledges
    logic [31:0] slave_rdata = 32'h0;
    int scnt = 0;                // s_valid cycles of the current transaction

    typedef struct {
        logic        who;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          waits;
    } exp_t;
    exp_t q[$];

    alphasoc_bus_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .err_timeout(err_timeout), .err_master(err_master), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic who, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] rdata, input int waits);
        exp_t e;
        e.who = who; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
        e.rdata = rdata; e.waits = waits;
        q.push_back(e);
    endtask

    task automatic issue(input logic who, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
        if (who) begin
            m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; m1_valid = 1'b1;
        end else begin
            m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; m0_valid = 1'b1;
        end
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 300 && done_cnt < target; i++) begin
            @(negedge clk);
            #1;
        end
        chk("wait_done", done_cnt, target);
    endtask

    // Slave model: acknowledges on the (slave_lat+1)-th cycle of s_valid.
    initial begin
        s_ready = 1'b0;
        s_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (s_valid) begin
                scnt++;
                s_ready = (slave_lat >= 0) && (scnt == slave_lat + 1);
                s_rdata = s_ready ? slave_rdata : 32'h0;
            end else begin
                scnt    = 0;
                s_ready = 1'b0;
                s_rdata = 32'h0;
            end
        end
    end

    // Monitor: every ready pulse is matched against the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (m0_ready || m1_ready)) begin
                chk("single_ready", {31'h0, m0_ready & m1_ready}, 32'h0);
                if (q.size() == 0) begin
                    chk("unexpected_ready", {31'h0, m1_ready}, {31'h0, ~m1_ready});
                end else begin
                    e = q.pop_front();
                    chk("who",   {31'h0, m1_ready}, {31'h0, e.who});
                    chk("rdata", e.who ? m1_rdata : m0_rdata, e.rdata);
                    chk("other_rdata", e.who ? m0_rdata : m1_rdata, 32'h0);
                    chk("s_addr",  s_addr,  e.addr);
                    chk("s_wdata", s_wdata, e.wdata);
                    chk("s_wstrb", {28'h0, s_wstrb}, {28'h0, e.wstrb});
                    chk("waits", scnt, e.waits);
                end
                done_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        reset = 1'b1; err_clear = 1'b0;
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        @(posedge clk); #1;
        chk("rst_s_valid", {31'h0, s_valid}, 32'h0);
        chk("rst_s_bus", s_addr | s_wdata | {28'h0, s_wstrb}, 32'h0);
        chk("rst_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        chk("rst_err", {30'h0, err_master, err_timeout}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Simultaneous requests out of reset: m0 first, then strict alternation.
        slave_lat = 0; slave_rdata = 32'hA5A5_0001;
        base = done_cnt;
        @(posedge clk); #1;
        issue(0, 32'h0000_0100, 32'h0, 4'h0);
        issue(1, 32'h0000_0200, 32'h0, 4'h0);
        push(0, 32'h0000_0100, 32'h0, 4'h0, 32'hA5A5_0001, 1);
        push(1, 32'h0000_0200, 32'h0, 4'h0, 32'hA5A5_0001, 1);
        push(0, 32'h0000_0100, 32'h0, 4'h0, 32'hA5A5_0001, 1);
        push(1, 32'h0000_0200, 32'h0, 4'h0, 32'hA5A5_0001, 1);
        wait_done(base + 4);
        @(posedge clk); #1;
        m0_valid = 0; m1_valid = 0;

        // m0 read, slave ready 3 cycles after s_valid.
        slave_lat = 3; slave_rdata = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        base = done_cnt;
        issue(0, 32'h0000_0010, 32'h0, 4'h0);
        push(0, 32'h0000_0010, 32'h0, 4'h0, 32'h1234_5678, 4);
        @(negedge clk);
        chk("t1_svalid_c0", {31'h0, s_valid}, 32'h0);
        @(negedge clk);
        chk("t1_svalid_c1", {31'h0, s_valid}, 32'h1);
        wait_done(base + 1);
        @(posedge clk); #1;
        m0_valid = 0;

        // m1 write while m0 requests one cycle later: m0 stalls until m1 finishes.
        slave_lat = 2; slave_rdata = 32'hCAFE_0003;
        repeat (2) @(posedge clk);
        #1;
        base = done_cnt;
        issue(1, 32'h0200_0008, 32'h0000_0041, 4'b0001);
        push(1, 32'h0200_0008, 32'h0000_0041, 4'b0001, 32'hCAFE_0003, 3);
        @(posedge clk); #1;
        issue(0, 32'h0000_0020, 32'h0, 4'h0);
        push(0, 32'h0000_0020, 32'h0, 4'h0, 32'hCAFE_0003, 3);
        wait_done(base + 1);
        @(posedge clk); #1;
        m1_valid = 0;
        wait_done(base + 2);
        @(posedge clk); #1;
        m0_valid = 0;

        // m0 timeout with a silent slave.
        slave_lat = -1;
        repeat (2) @(posedge clk);
        #1;
        base = done_cnt;
        issue(0, 32'h0000_0030, 32'h0, 4'h0);
        push(0, 32'h0000_0030, 32'h0, 4'h0, 32'hDEAD_BEEF, 8);
        wait_done(base + 1);
        @(posedge clk); #1;
        m0_valid = 0;
        chk("t4_err_timeout", {31'h0, err_timeout}, 32'h1);
        chk("t4_err_master", {31'h0, err_master}, 32'h0);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        chk("t4_err_cleared", {31'h0, err_timeout}, 32'h0);

        // m1 timeout with err_clear held: the set wins.
        repeat (2) @(posedge clk);
        #1;
        base = done_cnt;
        err_clear = 1'b1;
        issue(1, 32'h0000_0040, 32'h0, 4'h0);
        push(1, 32'h0000_0040, 32'h0, 4'h0, 32'hDEAD_BEEF, 8);
        wait_done(base + 1);
        @(posedge clk); #1;
        m1_valid = 0; err_clear = 1'b0;
        chk("m1to_err_timeout", {31'h0, err_timeout}, 32'h1);
        chk("m1to_err_master", {31'h0, err_master}, 32'h1);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        chk("m1to_err_cleared", {31'h0, err_timeout}, 32'h0);

        // Slave ready exactly on the timeout cycle: normal completion.
        slave_lat = 7; slave_rdata = 32'h5555_AAAA;
        repeat (2) @(posedge clk);
        #1;
        base = done_cnt;
        issue(0, 32'h0000_0050, 32'h0, 4'h0);
        push(0, 32'h0000_0050, 32'h0, 4'h0, 32'h5555_AAAA, 8);
        wait_done(base + 1);
        @(posedge clk); #1;
        m0_valid = 0;
        chk("t5_no_err", {31'h0, err_timeout}, 32'h0);

        // Master drops valid mid-transaction: bus released, no ready, no error.
        slave_lat = -1;
        repeat (2) @(posedge clk);
        #1;
        issue(0, 32'h0000_0060, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        m0_valid = 0;
        @(negedge clk);
        chk("drop_s_valid", {31'h0, s_valid}, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        chk("drop_no_err", {31'h0, err_timeout}, 32'h0);

        // Reset while m1 waits, then m0 must win the next tie.
        issue(1, 32'h0000_0070, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("t6_s_valid", {31'h0, s_valid}, 32'h0);
        chk("t6_m1_ready", {31'h0, m1_ready}, 32'h0);
        chk("t6_s_addr", s_addr, 32'h0);
        m1_valid = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        slave_lat = 0; slave_rdata = 32'h0000_BEEF;
        @(posedge clk); #1;
        base = done_cnt;
        issue(0, 32'h0000_0080, 32'h0, 4'h0);
        issue(1, 32'h0000_0090, 32'h0, 4'h0);
        push(0, 32'h0000_0080, 32'h0, 4'h0, 32'h0000_BEEF, 1);
        push(1, 32'h0000_0090, 32'h0, 4'h0, 32'h0000_BEEF, 1);
        wait_done(base + 2);
        @(posedge clk); #1;
        m0_valid = 0; m1_valid = 0;

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
